elevator_scan_controller: RTL and testbench
===========================================

ELEVATOR_SCAN_CONTROLLER -- requirements
Module: elevator_scan_controller

Interface
REQ-001 SHALL have parameter NUM_FLOORS, default 8, number of serviced floors (min 2).
REQ-002 SHALL have parameter FLOOR_W, default 3, floor index width (clog2 of NUM_FLOORS).
REQ-003 SHALL have parameter TRAVEL_CYCLES, default 4, clocks per one-floor move (min 1).
REQ-004 SHALL have parameter DOOR_CYCLES, default 3, clocks the door stays open (min 1).
REQ-005 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 SHALL have port req_valid  input  1  floor request strobe, sampled each clock.
REQ-008 SHALL have port req_floor  input  FLOOR_W  requested floor index.
REQ-009 SHALL have port door_status  input  1  door sensor (1 = open).
REQ-010 SHALL have port weight_status  input  1  overload sensor (1 = overweight).
REQ-011 SHALL have port cur_floor  output  FLOOR_W  current floor.
REQ-012 SHALL have port direction  output  1  1 = up, 0 = down.
REQ-013 SHALL have port moving  output  1  high in MOVE state.
REQ-014 SHALL have port door_open  output  1  door-open command, high in DOOR state.
REQ-015 SHALL have port arrived  output  1  one-cycle pulse on servicing a floor.
REQ-016 SHALL have port pending  output  NUM_FLOORS  outstanding request bitmap.
REQ-017 SHALL have port door_alert  output  1  door open while moving.
REQ-018 SHALL have port weight_alert  output  1  overload with door held.

Function
REQ-019 SHALL set pending[req_floor] on req_valid when req_floor < NUM_FLOORS; out-of-range requests SHALL be dropped silently.
REQ-020 SHALL implement FSM states IDLE, MOVE, DOOR; all outputs registered.
REQ-021 IDLE: if pending[cur_floor] set -> DOOR next cycle; else if any pending bit set -> MOVE toward it, preferring current direction; else stay IDLE.
REQ-022 MOVE: travel counter counts TRAVEL_CYCLES clocks, then cur_floor steps +/-1 per direction and counter reloads.
REQ-023 On reaching a floor with pending bit set: same edge clears that bit, pulses arrived, enters DOOR.
REQ-024 On reaching a floor with no pending bit: continue if pending bits remain ahead in direction; else reverse if any behind; else IDLE.
REQ-025 SCAN rule: direction SHALL only reverse when no pending bit lies strictly ahead.
REQ-026 direction SHALL be forced down at floor NUM_FLOORS-1 and up at floor 0; cur_floor never wraps.
REQ-027 DOOR: door timer counts DOOR_CYCLES clocks; at expiry, if weight_status=0 -> re-evaluate as IDLE rules (REQ-021) the next cycle; if weight_status=1 -> remain in DOOR, weight_alert=1, timer reloads.
REQ-028 weight_alert SHALL clear one cycle after weight_status returns to 0; it SHALL stay 0 outside DOOR.
REQ-029 door_alert SHALL assert the cycle after door_status=1 is sampled in MOVE; while asserted the travel counter freezes; it clears one cycle after door_status=0 and counting resumes.
REQ-030 A request for cur_floor during DOOR SHALL not set pending; it reloads the door timer.
REQ-031 Simultaneous request and clear of the same bit: clear wins; other bits set normally.
REQ-032 A request arriving in the same cycle IDLE evaluates SHALL be seen on the following cycle (one-cycle request latency).

Reset
REQ-033 While rst=0 at a clock edge: state IDLE, cur_floor=0, direction=1, moving=0, door_open=0, arrived=0, pending=0, door_alert=0, weight_alert=0, counters cleared.
REQ-034 Reset asserted mid-MOVE or mid-DOOR SHALL abort immediately with all pending requests discarded.
REQ-035 Requests sampled while rst=0 SHALL be ignored.

Verification (NUM_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-036 Reset, request floor 3 -> moving after 1 cycle, cur_floor 1,2,3 every 4 clocks, arrived pulse at floor 3, door_open 3 clocks, IDLE, pending=0.
REQ-037 At floor 2 moving up, requests 5 and 0 -> services 5 first then reverses, services 0; direction 1 then 0.
REQ-038 Door expiry with weight_status=1 for 10 clocks -> weight_alert high, door_open held, closes 1 cycle after weight_status drops.
REQ-039 door_status=1 for 5 clocks mid-MOVE -> door_alert high, cur_floor frozen, travel resumes from held count.
REQ-040 req_floor=9 with FLOOR_W=4, NUM_FLOORS=8 -> pending unchanged; request of cur_floor in IDLE -> door opens, no motion.
REQ-041 rst=0 mid-MOVE at floor 4 with pending=8'h81 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/elevator_scan_controller.sv
// elevator_scan_controller: SCAN elevator with request bitmap, timed travel/door and sensor alerts
module elevator_scan_controller #(
  parameter int NUM_FLOORS    = 8,
  parameter int FLOOR_W       = 3,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [FLOOR_W-1:0]    req_floor,
  input  logic                  door_status,
  input  logic                  weight_status,
  output logic [FLOOR_W-1:0]    cur_floor,
  output logic                  direction,
  output logic                  moving,
  output logic                  door_open,
  output logic                  arrived,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_alert,
  output logic                  weight_alert
);
  localparam int TW = $clog2(TRAVEL_CYCLES + 1);
  localparam int DW = $clog2(DOOR_CYCLES + 1);
  localparam logic [FLOOR_W-1:0] TOP = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W:0] NFW = (FLOOR_W + 1)'(NUM_FLOORS);
  localparam logic [NUM_FLOORS-1:0] ONE = NUM_FLOORS'(1);
  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  state_t state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d, nf;
  logic [NUM_FLOORS-1:0] pend_q, pend_d, set_m, clr_m, cur_oh, nf_oh;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic dir_q, dir_d, arr_q, arr_d, dal_q, dal_d, wal_q, wal_d;
  logic req_ok, req_here, t_exp, d_exp;
  // any pending floor strictly beyond the one-hot position in the given direction
  function automatic logic ahead(input logic [NUM_FLOORS-1:0] p, input logic [NUM_FLOORS-1:0] oh,
                                 input logic up);
    return |(p & (up ? ~((oh << 1) - ONE) : (oh - ONE)));
  endfunction
  always_comb begin
    req_ok = req_valid && ({1'b0, req_floor} < NFW);
    req_here = req_valid && (req_floor == floor_q);
    cur_oh = ONE << floor_q;
    nf = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    nf_oh = ONE << nf;
    t_exp = tcnt_q == TW'(TRAVEL_CYCLES - 1);
    d_exp = dcnt_q == DW'(DOOR_CYCLES - 1);
    set_m = (req_ok && !(state_q == DOOR && req_here)) ? ONE << req_floor : '0;
    state_d = state_q;
    floor_d = floor_q;
    dir_d = dir_q;
    tcnt_d = tcnt_q;
    dcnt_d = dcnt_q;
    clr_m = '0;
    arr_d = 1'b0;
    wal_d = 1'b0;
    case (state_q)
      IDLE:
        if (|(pend_q & cur_oh)) begin
          clr_m = cur_oh;
          arr_d = 1'b1;
          state_d = DOOR;
          dcnt_d = '0;
        end else if (|pend_q) begin
          dir_d = ahead(pend_q, cur_oh, dir_q) ? dir_q : !dir_q;
          state_d = MOVE;
          tcnt_d = '0;
        end
      MOVE:
        if (!dal_q) begin
          if (!t_exp) tcnt_d = tcnt_q + TW'(1);
          else begin
            tcnt_d = '0;
            floor_d = nf;
            if (|(pend_q & nf_oh)) begin
              clr_m = nf_oh;
              arr_d = 1'b1;
              state_d = DOOR;
              dcnt_d = '0;
            end else if (!ahead(pend_q, nf_oh, dir_q)) begin
              if (ahead(pend_q, nf_oh, !dir_q)) dir_d = !dir_q;
              else state_d = IDLE;
            end
            if (nf == TOP) dir_d = 1'b0;
            else if (nf == '0) dir_d = 1'b1;
          end
        end
      DOOR:
        if (wal_q && !weight_status) state_d = IDLE;
        else begin
          wal_d = wal_q;
          if (req_here) dcnt_d = '0;
          else if (!d_exp) dcnt_d = dcnt_q + DW'(1);
          else begin
            dcnt_d = '0;
            wal_d = weight_status;
            if (!weight_status) state_d = IDLE;
          end
        end
      default: state_d = IDLE;
    endcase
    dal_d = (state_q == MOVE) && (state_d == MOVE) && door_status;
    pend_d = (pend_q | set_m) & ~clr_m;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      floor_q <= '0;
      dir_q <= 1'b1;
      pend_q <= '0;
      tcnt_q <= '0;
      dcnt_q <= '0;
      arr_q <= 1'b0;
      dal_q <= 1'b0;
      wal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q <= dir_d;
      pend_q <= pend_d;
      tcnt_q <= tcnt_d;
      dcnt_q <= dcnt_d;
      arr_q <= arr_d;
      dal_q <= dal_d;
      wal_q <= wal_d;
    end
  end
  assign cur_floor = floor_q;
  assign direction = dir_q;
  assign moving = state_q == MOVE;
  assign door_open = state_q == DOOR;
  assign arrived = arr_q;
  assign pending = pend_q;
  assign door_alert = dal_q;
  assign weight_alert = wal_q;
endmodule

// File: tb/tb_elevator_scan_controller.sv
// tb_elevator_scan_controller: directed scenarios plus random traffic against a behavioural elevator model
module tb_elevator_scan_controller;
  logic clk = 1'b0, rst = 1'b0, req_valid = 1'b0, door_status = 1'b0, weight_status = 1'b0;
  logic [3:0] req_floor = '0, cur_floor;
  logic direction, moving, door_open, arrived, door_alert, weight_alert;
  logic [7:0] pending;
  int checks = 0, errors = 0;
  bit [7:0] m_pend;
  int m_floor, m_tl, m_dl;
  bit m_up, m_mov, m_door, m_arr, m_da, m_wa;
  elevator_scan_controller #(.NUM_FLOORS(8), .FLOOR_W(4), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor), .door_status(door_status),
    .weight_status(weight_status), .cur_floor(cur_floor), .direction(direction), .moving(moving),
    .door_open(door_open), .arrived(arrived), .pending(pending), .door_alert(door_alert),
    .weight_alert(weight_alert));
  always #5 clk = ~clk;
  function automatic bit any_dir(int f, bit up);
    for (int i = 0; i < 8; i++) if (m_pend[i] && (up ? i > f : i < f)) return 1'b1;
    return 1'b0;
  endfunction
  task automatic model_step();
    bit [7:0] set_b = '0, clr_b = '0;
    if (!rst) begin
      m_pend = '0; m_floor = 0; m_up = 1; m_mov = 0; m_door = 0; m_arr = 0; m_da = 0; m_wa = 0;
      return;
    end
    if (req_valid && req_floor < 8 && !(m_door && req_floor == m_floor)) set_b[req_floor] = 1'b1;
    m_arr = 0;
    if (m_mov) begin
      if (!m_da) begin
        m_tl--;
        if (m_tl == 0) begin
          m_tl = 4;
          m_floor += m_up ? 1 : -1;
          if (m_pend[m_floor]) begin
            clr_b[m_floor] = 1'b1; m_arr = 1; m_mov = 0; m_door = 1; m_dl = 3;
          end else if (!any_dir(m_floor, m_up)) begin
            if (any_dir(m_floor, !m_up)) m_up = !m_up;
            else m_mov = 0;
          end
          if (m_floor == 7) m_up = 0;
          if (m_floor == 0) m_up = 1;
        end
      end
      m_da = m_mov && door_status;
    end else if (m_door) begin
      if (m_wa && !weight_status) begin
        m_door = 0; m_wa = 0;
      end else if (req_valid && req_floor == m_floor) m_dl = 3;
      else begin
        m_dl--;
        if (m_dl == 0) begin
          m_dl = 3;
          if (weight_status) m_wa = 1;
          else m_door = 0;
        end
      end
    end else if (m_pend[m_floor]) begin
      clr_b[m_floor] = 1'b1; m_arr = 1; m_door = 1; m_dl = 3;
    end else if (m_pend != 0) begin
      if (!any_dir(m_floor, m_up)) m_up = !m_up;
      m_mov = 1; m_tl = 4;
    end
    m_pend = (m_pend | set_b) & ~clr_b;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("cur_floor", 32'(cur_floor), 32'(m_floor));
    chk("direction", 32'(direction), 32'(m_up));
    chk("moving", 32'(moving), 32'(m_mov));
    chk("door_open", 32'(door_open), 32'(m_door));
    chk("arrived", 32'(arrived), 32'(m_arr));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("door_alert", 32'(door_alert), 32'(m_da));
    chk("weight_alert", 32'(weight_alert), 32'(m_wa));
  endtask
  task automatic req(input int f);
    req_valid = 1'b1;
    req_floor = 4'(f);
    tick();
    req_valid = 1'b0;
  endtask
  task automatic reset_dut();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask
  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_floor"}, 32'(cur_floor), 0);
    chk({tag, "_dir"}, 32'(direction), 1);
    chk({tag, "_flags"}, 32'({moving, door_open, arrived, door_alert, weight_alert}), 0);
    chk({tag, "_pending"}, 32'(pending), 0);
  endtask
  initial begin
    reset_dut();
    chk_reset_outputs("rst0");
    req(3);
    chk("r36_pend", 32'(pending), 32'h08);
    tick();
    chk("r36_moving", 32'(moving), 1);
    repeat (12) tick();
    chk("r36_floor3", 32'(cur_floor), 3);
    chk("r36_arrived", 32'(arrived), 1);
    chk("r36_door", 32'(door_open), 1);
    chk("r36_pend0", 32'(pending), 0);
    repeat (3) tick();
    chk("r36_closed", 32'({door_open, moving}), 0);
    req(9);
    chk("r40_drop", 32'(pending), 0);
    req(3);
    tick();
    chk("r40_door", 32'({door_open, moving}), 32'b10);
    chk("r40_floor", 32'(cur_floor), 3);
    repeat (3) tick();
    reset_dut();
    req(5);
    for (int i = 0; i < 100 && cur_floor != 2; i++) tick();
    chk("r37_at2", 32'(cur_floor), 2);
    req(0);
    for (int i = 0; i < 100 && !arrived; i++) tick();
    chk("r37_svc5", 32'(cur_floor), 5);
    chk("r37_dir_up", 32'(direction), 1);
    for (int i = 0; i < 100 && !(moving && cur_floor == 3); i++) tick();
    chk("r37_dir_down", 32'(direction), 0);
    for (int i = 0; i < 100 && !arrived; i++) tick();
    chk("r37_svc0", 32'(cur_floor), 0);
    reset_dut();
    weight_status = 1'b1;
    req(0);
    repeat (4) tick();
    chk("r38_walert", 32'({weight_alert, door_open}), 32'b11);
    repeat (5) tick();
    chk("r38_held", 32'({weight_alert, door_open}), 32'b11);
    weight_status = 1'b0;
    tick();
    chk("r38_release", 32'({weight_alert, door_open}), 0);
    reset_dut();
    req(7);
    tick();
    tick();
    door_status = 1'b1;
    repeat (5) tick();
    chk("r39_alert", 32'({door_alert, moving}), 32'b11);
    chk("r39_frozen", 32'(cur_floor), 0);
    door_status = 1'b0;
    tick();
    chk("r39_clear", 32'(door_alert), 0);
    repeat (2) tick();
    chk("r39_resume", 32'(cur_floor), 1);
    reset_dut();
    req(7);
    for (int i = 0; i < 100 && cur_floor != 4; i++) tick();
    req(0);
    chk("r41_pend", 32'(pending), 32'h81);
    rst = 1'b0;
    tick();
    chk_reset_outputs("r41");
    rst = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rst = $urandom_range(0, 299) != 0;
      req_valid = $urandom_range(0, 4) == 0;
      req_floor = 4'($urandom_range(0, 9));
      door_status = $urandom_range(0, 14) == 0;
      weight_status = $urandom_range(0, 7) == 0;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
